npn_tt_sweep_ctrl: RTL and testbench

- Sequencer for a 4-input single-output combinational NPN cell (inputs x0..x3, output y0).
- Drives the cell's inputs through all 16 minterms under a requested NPN transform: input permutation, input negation and output negation.
- Collects the resulting 16-bit truth table and returns it over a valid/ready handshake.
- Sits between the exact-synthesis test/characterisation logic and any instantiated NPN cell.

---
 rtl/npn_tt_sweep_ctrl.sv | 179 +++++++++++++++++
 tb/tb_npn_tt_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/npn_tt_sweep_ctrl.sv
// npn_tt_sweep_ctrl
// Sweeps a 4-input, 1-output NPN cell through all 16 minterms under a
// requested transform (input permutation, input negation, output negation)
// and returns the collected 16-bit truth table over a valid/ready handshake.
//
// Optional build macro: NPN_SWEEP_CHECK_EN
//   Adds cfg_expect / res_match / res_mismatch_cnt. The mismatch count is
//   accumulated one bit per sample edge so no wide popcount is needed at
//   the end of the sweep.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | start_ready=1, waiting for start_valid; x_out=0
// ST_SWEEP | walking m=0..15, holding each minterm SETTLE_CYCLES cycles
// ST_DONE  | res_valid=1, result held until res_ready; x_out=0

module npn_tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [7:0]  cfg_perm,
  input  logic [3:0]  cfg_neg,
  input  logic        cfg_oneg,
`ifdef NPN_SWEEP_CHECK_EN
  input  logic [15:0] cfg_expect,
  output logic        res_match,
  output logic [4:0]  res_mismatch_cnt,
`endif
  output logic [3:0]  x_out,
  input  logic        y_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_tt,
  output logic        res_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  m_q;
  logic [3:0]  s_q;
  logic [7:0]  perm_q;
  logic [3:0]  neg_q;
  logic        oneg_q;

  logic [3:0]  perm_seen;
  logic        perm_ok;
  logic        accept;
  logic        sample_edge;
  logic        sample_bit;

  // A permutation is legal exactly when every one of the four targets is hit.
  always_comb begin
    perm_seen = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      perm_seen[cfg_perm[2*i +: 2]] = 1'b1;
    end
    perm_ok = &perm_seen;
  end

  assign accept      = (state_q == ST_IDLE) && start_valid;
  assign sample_edge = (state_q == ST_SWEEP) && (s_q == SETTLE_LAST);
  assign sample_bit  = y_in ^ oneg_q;

  // Cell input drive: transformed minterm during the sweep, all-zero otherwise.
  always_comb begin
    x_out = 4'b0000;
    if (state_q == ST_SWEEP) begin
      for (int i = 0; i < 4; i++) begin
        x_out[i] = m_q[perm_q[2*i +: 2]] ^ neg_q[i];
      end
    end
  end

  // Main sequencer: request latch, minterm/settle counters and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      m_q         <= 4'd0;
      s_q         <= 4'd0;
      perm_q      <= 8'h00;
      neg_q       <= 4'h0;
      oneg_q      <= 1'b0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      res_tt      <= 16'h0000;
      res_cfg_err <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_valid) begin
            perm_q      <= cfg_perm;
            neg_q       <= cfg_neg;
            oneg_q      <= cfg_oneg;
            m_q         <= 4'd0;
            s_q         <= 4'd0;
            res_tt      <= 16'h0000;
            start_ready <= 1'b0;
            if (!perm_ok) begin
              // Illegal permutation: report immediately, skip the sweep.
              state_q     <= ST_DONE;
              res_cfg_err <= 1'b1;
              res_valid   <= 1'b1;
            end else begin
              state_q     <= ST_SWEEP;
              res_cfg_err <= 1'b0;
            end
          end
        end

        ST_SWEEP: begin
          if (s_q == SETTLE_LAST) begin
            res_tt[m_q] <= sample_bit;
            s_q         <= 4'd0;
            m_q         <= m_q + 4'd1;
            if (m_q == 4'd15) begin
              state_q   <= ST_DONE;
              res_valid <= 1'b1;
            end
          end else begin
            s_q <= s_q + 4'd1;
          end
        end

        ST_DONE: begin
          // res_valid is always high here, so res_ready alone completes it.
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          start_ready <= 1'b1;
          res_valid   <= 1'b0;
        end
      endcase
    end
  end

`ifdef NPN_SWEEP_CHECK_EN
  logic [15:0] expect_q;
  logic        diff_bit;
  logic [4:0]  cnt_next;

  assign diff_bit = sample_bit ^ expect_q[m_q];
  assign cnt_next = res_mismatch_cnt + {4'b0000, diff_bit};

  // Expected-table compare, one bit folded into the count per sample edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      expect_q         <= 16'h0000;
      res_match        <= 1'b0;
      res_mismatch_cnt <= 5'd0;
    end else if (accept) begin
      expect_q         <= cfg_expect;
      res_match        <= 1'b0;
      res_mismatch_cnt <= perm_ok ? 5'd0 : 5'd16;
    end else if (sample_edge) begin
      res_mismatch_cnt <= cnt_next;
      if (m_q == 4'd15) begin
        res_match <= (cnt_next == 5'd0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_npn_tt_sweep_ctrl.sv
// Directed bench for npn_tt_sweep_ctrl: one instance with SETTLE_CYCLES=1
// driving a y=x0 cell, one with SETTLE_CYCLES=3 driving a 4-input AND cell
// whose output lags its inputs by two clocks.
module tb_npn_tt_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sv1, sv3;
  logic        sr1, sr3;
  logic [7:0]  perm;
  logic [3:0]  neg;
  logic        oneg;
  logic [3:0]  x1, x3;
  logic        y1, y3;
  logic        rv1, rv3;
  logic        rr1, rr3;
  logic [15:0] tt1, tt3;
  logic        err1, err3;
`ifdef NPN_SWEEP_CHECK_EN
  logic [15:0] expv;
  logic        match1, match3;
  logic [4:0]  cnt1, cnt3;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Cell for dut1: y = x0.
  assign y1 = x1[0];

  // Cell for dut3: y = &x, delayed two clocks so early sampling would be wrong.
  logic d1 = 1'b0, d2 = 1'b0;
  always @(posedge clk) begin
    d1 <= &x3;
    d2 <= d1;
  end
  assign y3 = d2;

  npn_tt_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1),
    .cfg_perm(perm), .cfg_neg(neg), .cfg_oneg(oneg),
`ifdef NPN_SWEEP_CHECK_EN
    .cfg_expect(expv), .res_match(match1), .res_mismatch_cnt(cnt1),
`endif
    .x_out(x1), .y_in(y1), .res_valid(rv1), .res_ready(rr1),
    .res_tt(tt1), .res_cfg_err(err1)
  );

  npn_tt_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start_valid(sv3), .start_ready(sr3),
    .cfg_perm(perm), .cfg_neg(neg), .cfg_oneg(oneg),
`ifdef NPN_SWEEP_CHECK_EN
    .cfg_expect(expv), .res_match(match3), .res_mismatch_cnt(cnt3),
`endif
    .x_out(x3), .y_in(y3), .res_valid(rv3), .res_ready(rr3),
    .res_tt(tt3), .res_cfg_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accept edge.
  task automatic issue(input bit which, input logic [7:0] p, input logic [3:0] n, input logic o);
    perm = p;
    neg  = n;
    oneg = o;
    if (which) sv3 = 1'b1;
    else       sv1 = 1'b1;
    step();
    sv1 = 1'b0;
    sv3 = 1'b0;
  endtask

  // Cycles from the accept edge until res_valid, bounded.
  task automatic wait_valid(input bit which, output int cyc);
    cyc = 0;
    while (((which ? rv3 : rv1) == 1'b0) && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic handshake(input bit which, input string tag);
    if (which) rr3 = 1'b1;
    else       rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    rr3 = 1'b0;
    chk({tag, "_hs_valid"}, 32'(which ? rv3 : rv1), 32'd0);
    chk({tag, "_hs_ready"}, 32'(which ? sr3 : sr1), 32'd1);
  endtask

  initial begin
    int cyc;
    rst  = 1'b1;
    sv1  = 1'b0;
    sv3  = 1'b0;
    rr1  = 1'b0;
    rr3  = 1'b0;
    perm = 8'h00;
    neg  = 4'h0;
    oneg = 1'b0;
`ifdef NPN_SWEEP_CHECK_EN
    expv = 16'hAAAA;
`endif
    step();
    step();
    rst = 1'b0;

    chk("rst_start_ready", 32'(sr1), 32'd1);
    chk("rst_res_valid",   32'(rv1), 32'd0);
    chk("rst_res_tt",      32'(tt1), 32'd0);
    chk("rst_cfg_err",     32'(err1), 32'd0);
    chk("rst_x_out",       32'(x1), 32'd0);

    // Identity, y=x0: 0xAAAA, x_out walks 0..15, valid 16 cycles after accept.
    issue(1'b0, 8'hE4, 4'h0, 1'b0);
    chk("id_busy_ready", 32'(sr1), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("id_walk_x", 32'(x1), 32'(k));
      chk("id_walk_valid", 32'(rv1), 32'd0);
      step();
    end
    chk("id_valid", 32'(rv1), 32'd1);
    chk("id_tt", 32'(tt1), 32'hAAAA);
    chk("id_err", 32'(err1), 32'd0);
    chk("id_done_x", 32'(x1), 32'd0);
`ifdef NPN_SWEEP_CHECK_EN
    chk("id_match", 32'(match1), 32'd1);
    chk("id_cnt", 32'(cnt1), 32'd0);
`endif
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_hold", 32'({rv1, tt1}), 32'h1AAAA);
    end
    handshake(1'b0, "id");

    // Input 0 negated.
    issue(1'b0, 8'hE4, 4'h1, 1'b0);
    wait_valid(1'b0, cyc);
    chk("neg_cycles", 32'(cyc), 32'd16);
    chk("neg_tt", 32'(tt1), 32'h5555);
    handshake(1'b0, "neg");

    // Output negated.
    issue(1'b0, 8'hE4, 4'h0, 1'b1);
    wait_valid(1'b0, cyc);
    chk("oneg_cycles", 32'(cyc), 32'd16);
    chk("oneg_tt", 32'(tt1), 32'h5555);
    handshake(1'b0, "oneg");

    // Swap inputs 0 and 1: cell sees m[1] on x0.
    issue(1'b0, 8'hE1, 4'h0, 1'b0);
    wait_valid(1'b0, cyc);
    chk("swap_cycles", 32'(cyc), 32'd16);
    chk("swap_tt", 32'(tt1), 32'hCCCC);
    handshake(1'b0, "swap");

    // Illegal permutation: immediate error result, no sweep.
    issue(1'b0, 8'h00, 4'h0, 1'b0);
    chk("err_x_out", 32'(x1), 32'd0);
    wait_valid(1'b0, cyc);
    chk("err_cycles", 32'(cyc), 32'd0);
    chk("err_flag", 32'(err1), 32'd1);
    chk("err_tt", 32'(tt1), 32'd0);
`ifdef NPN_SWEEP_CHECK_EN
    chk("err_match", 32'(match1), 32'd0);
    chk("err_cnt", 32'(cnt1), 32'd16);
`endif
    handshake(1'b0, "err");

    // Reset in the middle of a sweep at m=7.
    issue(1'b0, 8'hE4, 4'h0, 1'b0);
    chk("mid_err_cleared", 32'(err1), 32'd0);
    for (int k = 0; k < 7; k++) step();
    chk("mid_x7", 32'(x1), 32'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", 32'(sr1), 32'd1);
    chk("mid_rst_valid", 32'(rv1), 32'd0);
    chk("mid_rst_x", 32'(x1), 32'd0);
    chk("mid_rst_tt", 32'(tt1), 32'd0);

    // SETTLE_CYCLES=3 with a two-cycle-latency AND cell.
    issue(1'b1, 8'hE4, 4'h0, 1'b0);
    wait_valid(1'b1, cyc);
    chk("and_cycles", 32'(cyc), 32'd48);
    chk("and_tt", 32'(tt3), 32'h8000);
    handshake(1'b1, "and");

    issue(1'b1, 8'hE4, 4'hF, 1'b0);
    wait_valid(1'b1, cyc);
    chk("andneg_cycles", 32'(cyc), 32'd48);
    chk("andneg_tt", 32'(tt3), 32'h0001);
    handshake(1'b1, "andneg");

`ifdef NPN_SWEEP_CHECK_EN
    // One-bit disagreement at minterm 0.
    expv = 16'hAAAB;
    issue(1'b0, 8'hE4, 4'h0, 1'b0);
    wait_valid(1'b0, cyc);
    chk("chk_tt", 32'(tt1), 32'hAAAA);
    chk("chk_match", 32'(match1), 32'd0);
    chk("chk_cnt", 32'(cnt1), 32'd1);
    handshake(1'b0, "chk");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
